// File: rtl/flt_cfg_burst_sequencer.sv
// Burst command front end for the forward-lookup-table config path: splits burst
// commands into single-word parser strobes and returns read words as a stream.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | ready for a burst command; len=0 commands are dropped
// ST_WR       | accepting write words, one parser write strobe per word
// ST_RD_ISSUE | parser read strobe for the current word is on the bus
// ST_RD_WAIT  | waiting for the matching read return, or for the timeout
// ST_RD_HOLD  | read word presented on the output stream until consumed

module flt_cfg_burst_sequencer #(
    parameter int LEN_W      = 8,
    parameter int RD_TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [18:0]      iv_cmd_addr,
    input  logic             i_cmd_addr_fixed,
    input  logic             i_cmd_rd,
    input  logic [LEN_W-1:0] iv_cmd_len,
    input  logic             i_wdata_valid,
    output logic             o_wdata_ready,
    input  logic [31:0]      iv_wdata,
    output logic             o_rdata_valid,
    input  logic             i_rdata_ready,
    output logic [31:0]      ov_rdata,
    output logic             o_rdata_err,
    output logic             o_rdata_last,
    output logic             o_cmd_err,
    output logic [18:0]      ov_flt_addr,
    output logic             o_flt_addr_fixed,
    output logic [31:0]      ov_flt_wdata,
    output logic             o_flt_wr,
    output logic             o_flt_rd,
    input  logic             i_flt_ret_wr,
    input  logic [18:0]      iv_flt_ret_addr,
    input  logic             i_flt_ret_addr_fixed,
    input  logic [31:0]      iv_flt_ret_rdata
);

    localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [18:0]        cur_addr_q, cur_addr_d;
    logic               fixed_q, fixed_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               cmd_err_q, cmd_err_d;
    logic [18:0]        flt_addr_q, flt_addr_d;
    logic               flt_fixed_q, flt_fixed_d;
    logic [31:0]        flt_wdata_q, flt_wdata_d;
    logic               flt_wr_q, flt_wr_d;
    logic               flt_rd_q, flt_rd_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rdata_err_q, rdata_err_d;
    logic               rdata_valid_q, rdata_valid_d;
    logic               rdata_last_q, rdata_last_d;

    logic cmd_hs;
    logic wr_hs;
    logic rd_hs;
    logic ret_match;
    logic last_word;

    assign cmd_hs    = cmd_ready_q && i_cmd_valid;
    assign wr_hs     = (state_q == ST_WR) && i_wdata_valid;
    assign rd_hs     = rdata_valid_q && i_rdata_ready;
    assign last_word = (rem_q == LEN_W'(1));
    assign ret_match = i_flt_ret_wr && (iv_flt_ret_addr == cur_addr_q)
                       && (i_flt_ret_addr_fixed == fixed_q);

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        fixed_d       = fixed_q;
        rem_d         = rem_q;
        tmr_d         = tmr_q;
        cmd_err_d     = 1'b0;
        flt_addr_d    = flt_addr_q;
        flt_fixed_d   = flt_fixed_q;
        flt_wdata_d   = flt_wdata_q;
        flt_wr_d      = 1'b0;
        flt_rd_d      = 1'b0;
        rdata_d       = rdata_q;
        rdata_err_d   = rdata_err_q;
        rdata_valid_d = rdata_valid_q;
        rdata_last_d  = rdata_last_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    cur_addr_d = iv_cmd_addr;
                    fixed_d    = i_cmd_addr_fixed;
                    rem_d      = iv_cmd_len;
                    if (iv_cmd_len == '0) begin
                        cmd_err_d = 1'b1;
                    end else if (i_cmd_rd) begin
                        state_d = ST_RD_ISSUE;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (wr_hs) begin
                    flt_wr_d    = 1'b1;
                    flt_addr_d  = cur_addr_q;
                    flt_fixed_d = fixed_q;
                    flt_wdata_d = iv_wdata;
                    cur_addr_d  = cur_addr_q + 19'd1;
                    rem_d       = rem_q - LEN_W'(1);
                    if (last_word) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                tmr_d   = TMR_W'(RD_TIMEOUT - 1);
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // A return arriving on the timeout cycle still counts as data.
                if (ret_match) begin
                    rdata_d       = iv_flt_ret_rdata;
                    rdata_err_d   = 1'b0;
                    rdata_valid_d = 1'b1;
                    rdata_last_d  = last_word;
                    state_d       = ST_RD_HOLD;
                end else if (tmr_q == '0) begin
                    rdata_d       = 32'd0;
                    rdata_err_d   = 1'b1;
                    rdata_valid_d = 1'b1;
                    rdata_last_d  = last_word;
                    state_d       = ST_RD_HOLD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_RD_HOLD: begin
                if (rd_hs) begin
                    rdata_valid_d = 1'b0;
                    rdata_err_d   = 1'b0;
                    rdata_last_d  = 1'b0;
                    if (last_word) begin
                        state_d = ST_IDLE;
                    end else begin
                        cur_addr_d = cur_addr_q + 19'd1;
                        rem_d      = rem_q - LEN_W'(1);
                        state_d    = ST_RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read strobe is registered so it lines up with the RD_ISSUE cycle.
        if (state_d == ST_RD_ISSUE) begin
            flt_rd_d    = 1'b1;
            flt_addr_d  = cur_addr_d;
            flt_fixed_d = fixed_d;
        end

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            cur_addr_q    <= '0;
            fixed_q       <= 1'b0;
            rem_q         <= '0;
            tmr_q         <= '0;
            cmd_ready_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            flt_addr_q    <= '0;
            flt_fixed_q   <= 1'b0;
            flt_wdata_q   <= '0;
            flt_wr_q      <= 1'b0;
            flt_rd_q      <= 1'b0;
            rdata_q       <= '0;
            rdata_err_q   <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            fixed_q       <= fixed_d;
            rem_q         <= rem_d;
            tmr_q         <= tmr_d;
            cmd_ready_q   <= cmd_ready_d;
            cmd_err_q     <= cmd_err_d;
            flt_addr_q    <= flt_addr_d;
            flt_fixed_q   <= flt_fixed_d;
            flt_wdata_q   <= flt_wdata_d;
            flt_wr_q      <= flt_wr_d;
            flt_rd_q      <= flt_rd_d;
            rdata_q       <= rdata_d;
            rdata_err_q   <= rdata_err_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_last_q  <= rdata_last_d;
        end
    end

    assign o_cmd_ready      = cmd_ready_q;
    assign o_wdata_ready    = (state_q == ST_WR);
    assign o_rdata_valid    = rdata_valid_q;
    assign ov_rdata         = rdata_q;
    assign o_rdata_err      = rdata_err_q;
    assign o_rdata_last     = rdata_last_q;
    assign o_cmd_err        = cmd_err_q;
    assign ov_flt_addr      = flt_addr_q;
    assign o_flt_addr_fixed = flt_fixed_q;
    assign ov_flt_wdata     = flt_wdata_q;
    assign o_flt_wr         = flt_wr_q;
    assign o_flt_rd         = flt_rd_q;

endmodule
